// File: rtl/sonic_vc_rx_demux.sv
// Virtual-channel RX demux: steers each input packet onto one of NUM_CHAN channels
// through a single shared output register, and drops packets that have an illegal channel or no sop.
module sonic_vc_rx_demux #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_CHAN   = 2,
  parameter int unsigned CHAN_WIDTH = 3
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   rx_st_valid,
  input  logic                   rx_st_sop,
  input  logic                   rx_st_eop,
  input  logic                   rx_st_err,
  input  logic [DATA_WIDTH-1:0]  rx_st_data,
  input  logic [CHAN_WIDTH-1:0]  rx_chan,
  output logic                   rx_st_ready,
  output logic [NUM_CHAN-1:0]    out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   out_err,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic [NUM_CHAN-1:0]    out_ready,
  output logic [16*NUM_CHAN-1:0] pkt_cnt,
  output logic [15:0]            drop_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DROP} state_e;

  state_e                  state_q;
  logic [CHAN_WIDTH-1:0]   cur_chan_q;
  logic                    rdy_en_q;
  logic [NUM_CHAN-1:0]     valid_q;
  logic                    sop_q, eop_q, err_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [CNT_W-1:0]        pkt_q [NUM_CHAN];
  logic [CNT_W-1:0]        pkt_d [NUM_CHAN];
  logic [CNT_W-1:0]        drop_q, drop_d;

  logic                    drain_c, accept_c, legal_c, fwd_c, drop_c;
  logic [CHAN_WIDTH-1:0]   fwd_chan_c;
  logic [NUM_CHAN-1:0]     fwd_oh_c;

  // Handshake and beat disposition; the held beat is one-hot, so its drain is a reduction.
  always_comb begin
    drain_c     = |(valid_q & out_ready);
    rx_st_ready = rdy_en_q && (!(|valid_q) || drain_c);
    accept_c    = rx_st_valid && rx_st_ready;
    legal_c     = 32'(rx_chan) < NUM_CHAN;
    fwd_c       = accept_c && (rx_st_sop ? legal_c : (state_q == ST_PKT));
    drop_c      = accept_c && !fwd_c;
    fwd_chan_c  = rx_st_sop ? rx_chan : cur_chan_q;
    fwd_oh_c    = '0;
    for (int unsigned k = 0; k < NUM_CHAN; k++) begin
      if (32'(fwd_chan_c) == k) fwd_oh_c[k] = 1'b1;
    end
  end

  // Saturating counter next values.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CHAN; k++) begin
      pkt_d[k] = pkt_q[k];
      if (valid_q[k] && out_ready[k] && eop_q && (pkt_q[k] != CNT_MAX))
        pkt_d[k] = pkt_q[k] + CNT_W'(1);
    end
    drop_d = drop_q;
    if (drop_c && (drop_q != CNT_MAX)) drop_d = drop_q + CNT_W'(1);
  end

  // Packet framing FSM; any accepted sop restarts framing regardless of state.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_chan_q <= '0;
    end else if (accept_c) begin
      if (rx_st_sop) begin
        if (legal_c) begin
          cur_chan_q <= rx_chan;
          state_q    <= rx_st_eop ? ST_IDLE : ST_PKT;
        end else begin
          state_q    <= rx_st_eop ? ST_IDLE : ST_DROP;
        end
      end else if (rx_st_eop) begin
        state_q <= ST_IDLE;
      end
    end
  end

  // Shared output register and counters.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rdy_en_q <= 1'b0;
      valid_q  <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      drop_q   <= '0;
      for (int unsigned k = 0; k < NUM_CHAN; k++) pkt_q[k] <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      drop_q   <= drop_d;
      for (int unsigned k = 0; k < NUM_CHAN; k++) pkt_q[k] <= pkt_d[k];
      if (fwd_c) begin
        valid_q <= fwd_oh_c;
        sop_q   <= rx_st_sop;
        eop_q   <= rx_st_eop;
        err_q   <= rx_st_err;
        data_q  <= rx_st_data;
      end else if (drain_c) begin
        valid_q <= '0;
      end
    end
  end

  always_comb begin
    out_valid = valid_q;
    out_sop   = sop_q;
    out_eop   = eop_q;
    out_err   = err_q;
    out_data  = data_q;
    drop_cnt  = drop_q;
    for (int unsigned k = 0; k < NUM_CHAN; k++) pkt_cnt[k*CNT_W +: CNT_W] = pkt_q[k];
  end

endmodule
